// File: rtl/uart_rx_packet.sv
// ---------------------------------------------------------------------------
// uart_rx_packet
//
// Oversampling UART receiver. It turns one serial frame into one WIDTH-bit
// packet. A frame is a start bit (0), then WIDTH data bits LSB first, then a
// stop bit (1). This block checks framing only. Parity and magic-number
// checks are done downstream in comms_ctrl, which consumes rx_data and
// rx_data_flag.
//
// Optional feature macro: UART_RX_FRAME_ERR_EN
//   When defined, this block adds the frame_error and frame_err_count
//   outputs and the logic that drives them. When undefined, bad frames are
//   silently discarded.
//
// Parameters
//   WIDTH       packet width in bits
//   OVERSAMPLE  clk cycles per serial bit (even, >= 4)
//   FLAG_HOLD   cycles rx_data_flag stays high per good packet (>= 1)
//
// Ports
//   clk              in   primary clock
//   reset_n          in   asynchronous reset, active low
//   rx_in            in   serial line, idle high, asynchronous to clk
//   rx_data          out  last good packet, stable between good packets
//   rx_data_flag     out  high FLAG_HOLD cycles when a new packet lands
//   rx_busy          out  high from qualified start bit to stop-bit sample
//   frame_error      out  (macro only) 1-cycle pulse on a bad stop bit
//   frame_err_count  out  (macro only) saturating count of bad frames
// ---------------------------------------------------------------------------
module uart_rx_packet #(
    parameter int WIDTH      = 64,
    parameter int OVERSAMPLE = 4,
    parameter int FLAG_HOLD  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx_in,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_data_flag,
    output logic             rx_busy
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic             frame_error,
    output logic [7:0]       frame_err_count
`endif
);

    localparam int PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam int HW = $clog2(FLAG_HOLD + 1);

    localparam logic [PW-1:0] PHASE_MID  = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(FLAG_HOLD);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d, phase_wrap;
    logic [BW-1:0]   bit_q, bit_d;
    logic [HW-1:0]   hold_q;
    logic [WIDTH-1:0] shift_reg;
    logic [1:0]      sync_q;
    logic            rxs;

    // FSM action strobes, decoded in the next-state process
    logic shift_en;
    logic load_data;
    logic set_busy;
    logic clr_busy;
    logic frame_bad;

    // -----------------------------------------------------------------------
    // 2-flop synchronizer. Resets to the idle line level so a reset never
    // looks like a start bit.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_in};
        end
    end

    assign rxs = sync_q[1];

    // Free-running phase advance; wraps so DATA/STOP sample every OVERSAMPLE
    assign phase_wrap = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);

    // -----------------------------------------------------------------------
    // FSM state register and counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and action decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_wrap;
        bit_d     = bit_q;
        shift_en  = 1'b0;
        load_data = 1'b0;
        set_busy  = 1'b0;
        clr_busy  = 1'b0;
        frame_bad = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Phase held at 0 so START counts from the first low sample
                phase_d = '0;
                if (!rxs) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                // Half a bit in: confirm the start bit is still low.
                // Clearing phase here aligns later samples to mid-bit.
                if (phase_q == PHASE_MID) begin
                    phase_d = '0;
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_DATA;
                        bit_d    = '0;
                        set_busy = 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (phase_q == PHASE_LAST) begin
                    shift_en = 1'b1;
                    bit_d    = bit_q + BW'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end
                end
            end

            S_STOP: begin
                // Leaving at mid stop bit gives half a bit of slack to catch
                // a back-to-back start bit from IDLE.
                if (phase_q == PHASE_LAST) begin
                    clr_busy = 1'b1;
                    if (rxs) begin
                        load_data = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = S_BREAK;
                    end
                end
            end

            S_BREAK: begin
                // A line held low after a bad stop bit must not retrigger
                phase_d = '0;
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Shift register: right shift, newest bit enters at the MSB so the
    // first received (LSB) bit ends up in [0]. Internal only, so no reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (shift_en) begin
            shift_reg <= {rxs, shift_reg[WIDTH-1:1]};
        end
    end

    // -----------------------------------------------------------------------
    // Output registers: packet, flag hold counter, busy
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data <= '0;
            hold_q  <= '0;
            rx_busy <= 1'b0;
        end else begin
            if (load_data) begin
                rx_data <= shift_reg;
            end

            // A new packet while the flag is still up restarts the hold
            if (load_data) begin
                hold_q <= HOLD_LOAD;
            end else if (hold_q != '0) begin
                hold_q <= hold_q - HW'(1);
            end

            if (set_busy) begin
                rx_busy <= 1'b1;
            end else if (clr_busy) begin
                rx_busy <= 1'b0;
            end
        end
    end

    assign rx_data_flag = (hold_q != '0);

`ifdef UART_RX_FRAME_ERR_EN
    // -----------------------------------------------------------------------
    // Frame error pulse and saturating counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_error     <= 1'b0;
            frame_err_count <= 8'h00;
        end else begin
            frame_error <= frame_bad;
            if (frame_bad && (frame_err_count != 8'hFF)) begin
                frame_err_count <= frame_err_count + 8'h01;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_packet.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_packet
//
// Directed bench for uart_rx_packet (WIDTH=64, OVERSAMPLE=4, FLAG_HOLD=2).
// Good frames push their expected word into a queue; a monitor pops and
// compares it when rx_data_flag rises and also checks the flag width.
// Frame-error checks are compiled only when UART_RX_FRAME_ERR_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_rx_packet;

    localparam int WIDTH = 64;
    localparam int OS    = 4;
    localparam int FH    = 2;
`ifdef UART_RX_FRAME_ERR_EN
    localparam int N_ERR = 300;
`else
    localparam int N_ERR = 4;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             rx_in = 1'b1;
    logic [WIDTH-1:0] rx_data;
    logic             rx_data_flag;
    logic             rx_busy;
`ifdef UART_RX_FRAME_ERR_EN
    logic             frame_error;
    logic [7:0]       frame_err_count;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int flag_rises = 0;
    int fe_cycles  = 0;
    logic [WIDTH-1:0] exp_q[$];

    uart_rx_packet #(
        .WIDTH(WIDTH),
        .OVERSAMPLE(OS),
        .FLAG_HOLD(FH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_in(rx_in),
        .rx_data(rx_data),
        .rx_data_flag(rx_data_flag),
        .rx_busy(rx_busy)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_error(frame_error),
        .frame_err_count(frame_err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] d, input logic stop, input logic chk_busy);
        rx_in = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < WIDTH; i++) begin
            rx_in = d[i];
            repeat (OS) @(negedge clk);
            if (chk_busy && i == 10) check("busy_mid_frame", 64'(rx_busy), 64'd1);
        end
        rx_in = stop;
        repeat (OS) @(negedge clk);
    endtask

    // Scoreboard monitor
    initial begin
        logic flag_prev;
        int   flag_len;
        logic [WIDTH-1:0] exp_w;
        flag_prev = 1'b0;
        flag_len  = 0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (rx_data_flag && !flag_prev) begin
                    flag_rises++;
                    flag_len = 1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_flag", 64'd1, 64'd0);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("rx_data_at_flag", rx_data, exp_w);
                    end
                end else if (rx_data_flag) begin
                    flag_len++;
                end else if (flag_prev) begin
                    check("flag_width", 64'(flag_len), 64'(FH));
                end
`ifdef UART_RX_FRAME_ERR_EN
                if (frame_error) fe_cycles++;
`endif
            end
            flag_prev = rx_data_flag;
        end
    end

    initial begin
        logic busy_seen;
        int   rises0;
        int   fe0;

        // Reset state
        reset_n = 1'b0;
        rx_in   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_data", rx_data, 64'd0);
        check("reset_flag", 64'(rx_data_flag), 64'd0);
        check("reset_busy", 64'(rx_busy), 64'd0);
`ifdef UART_RX_FRAME_ERR_EN
        check("reset_frame_error", 64'(frame_error), 64'd0);
        check("reset_err_count", 64'(frame_err_count), 64'd0);
`endif
        reset_n = 1'b1;
        idle(5);

        // 1. Single good frame
        exp_q.push_back(64'h8000_0000_0000_0001);
        send_frame(64'h8000_0000_0000_0001, 1'b1, 1'b1);
        idle(8);
        check("t1_rx_data", rx_data, 64'h8000_0000_0000_0001);
        check("t1_busy_after", 64'(rx_busy), 64'd0);
        check("t1_flag_count", 64'(flag_rises), 64'd1);

        // 2. One-cycle glitch
        rx_in = 1'b0;
        @(negedge clk);
        rx_in = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            busy_seen |= rx_busy;
        end
        check("t2_glitch_busy", 64'(busy_seen), 64'd0);
        check("t2_rx_data", rx_data, 64'h8000_0000_0000_0001);
        check("t2_flag_count", 64'(flag_rises), 64'd1);

        // 3. Good 64'h1, then a frame with a bad stop bit, line held low
        exp_q.push_back(64'h1);
        send_frame(64'h1, 1'b1, 1'b0);
        idle(8);
        check("t3_good_rx_data", rx_data, 64'h1);
        fe0 = fe_cycles;
        send_frame(64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0);
        rx_in = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 10 * OS; i++) begin
            @(negedge clk);
            busy_seen |= rx_busy;
        end
        check("t3_break_busy", 64'(busy_seen), 64'd0);
        check("t3_rx_data_kept", rx_data, 64'h1);
        check("t3_flag_count", 64'(flag_rises), 64'd2);
`ifdef UART_RX_FRAME_ERR_EN
        check("t3_frame_error_cycles", 64'(fe_cycles - fe0), 64'd1);
        check("t3_err_count", 64'(frame_err_count), 64'd1);
`endif
        idle(8);

        // 4. Back-to-back frames with no idle bits
        exp_q.push_back(64'hA5A5_A5A5_A5A5_A5A5);
        exp_q.push_back(64'h5A5A_5A5A_5A5A_5A5A);
        send_frame(64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 1'b1);
        send_frame(64'h5A5A_5A5A_5A5A_5A5A, 1'b1, 1'b1);
        idle(8);
        check("t4_rx_data", rx_data, 64'h5A5A_5A5A_5A5A_5A5A);
        check("t4_flag_count", 64'(flag_rises), 64'd4);

        // 5. Reset at data bit 30, then a good 64'h0F
        rx_in = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            rx_in = 1'b1;
            repeat (OS) @(negedge clk);
        end
        reset_n = 1'b0;
        rx_in   = 1'b1;
        #1;
        check("t5_reset_rx_data", rx_data, 64'd0);
        check("t5_reset_busy", 64'(rx_busy), 64'd0);
        check("t5_reset_flag", 64'(rx_data_flag), 64'd0);
`ifdef UART_RX_FRAME_ERR_EN
        check("t5_reset_err_count", 64'(frame_err_count), 64'd0);
`endif
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle(8);
        rises0 = flag_rises;
        exp_q.push_back(64'h0F);
        send_frame(64'h0F, 1'b1, 1'b1);
        idle(8);
        check("t5_rx_data", rx_data, 64'h0F);
        check("t5_flag_count", 64'(flag_rises - rises0), 64'd1);

        // 6. Repeated stop-bit errors
        rises0 = flag_rises;
        fe0    = fe_cycles;
        for (int i = 0; i < N_ERR; i++) begin
            send_frame({32'(i), 32'hCAFE_0000}, 1'b0, 1'b0);
            idle(OS);
        end
        idle(8);
        check("t6_flag_count", 64'(flag_rises - rises0), 64'd0);
        check("t6_rx_data", rx_data, 64'h0F);
        check("t6_busy", 64'(rx_busy), 64'd0);
`ifdef UART_RX_FRAME_ERR_EN
        check("t6_err_count_sat", 64'(frame_err_count), 64'hFF);
        check("t6_frame_error_cycles", 64'(fe_cycles - fe0), 64'(N_ERR));
`endif

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
